// File: rtl/sd_block_demux.sv
// Start-token framed block demultiplexer: hunts for START_TOKEN in the SPI byte
// stream, reads a channel tag, routes the payload to one of NUM_CH writers, drops the CRC.
module sd_block_demux #(
    parameter int         NUM_CH        = 2,
    parameter int         BLOCK_BYTES   = 512,
    parameter int         CRC_BYTES     = 2,
    parameter logic [7:0] START_TOKEN   = 8'hFE,
    parameter int         TIMEOUT_BYTES = 4096
) (
    input  logic              CLK_40,
    input  logic              reset,
    input  logic              enable,
    input  logic              clr_err,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic [NUM_CH-1:0] ch_ready,
    output logic [NUM_CH-1:0] wr_en,
    output logic [7:0]        wr_data,
    output logic              block_done,
    output logic [2:0]        block_ch,
    output logic              timeout,
    output logic              abort,
    output logic              err_tag,
    output logic              err_ovf,
    output logic              busy
);

    localparam int CNT_W  = $clog2(BLOCK_BYTES + CRC_BYTES + 1);
    localparam int HUNT_W = $clog2(TIMEOUT_BYTES + 1);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  PAY_END  = CNT_W'(BLOCK_BYTES);
    localparam logic [CNT_W-1:0]  CRC_END  = CNT_W'(BLOCK_BYTES + CRC_BYTES);
    localparam logic [HUNT_W-1:0] HUNT_ONE = HUNT_W'(1);
    localparam logic [HUNT_W-1:0] HUNT_END = HUNT_W'(TIMEOUT_BYTES);
    localparam logic [7:0]        NUM_CH_B = 8'(NUM_CH);

    typedef enum logic [2:0] {
        IDLE,
        HUNT,
        TAG,
        PAYLOAD,
        CRC
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   byte_cnt, byte_cnt_nxt;
    logic [HUNT_W-1:0]  hunt_cnt, hunt_cnt_nxt;
    logic [CH_W-1:0]    cur_ch, cur_ch_nxt;
    logic               discard, discard_nxt;

    logic [NUM_CH-1:0]  wr_en_nxt;
    logic [7:0]         wr_data_nxt;
    logic               block_done_nxt;
    logic [2:0]         block_ch_nxt;
    logic               timeout_nxt;
    logic               abort_nxt;
    logic               err_tag_nxt;
    logic               err_ovf_nxt;

    logic [CNT_W-1:0]   byte_inc;
    logic [HUNT_W-1:0]  hunt_inc;
    logic [CH_W-1:0]    tag_ch;
    logic               tag_bad;
    logic               in_block;
    logic               sel_ready;
    logic [NUM_CH-1:0]  sel_onehot;
    logic               end_payload;
    logic               end_block;
    logic               end_discard;
    logic [CH_W-1:0]    end_ch;

    assign byte_inc = byte_cnt + CNT_ONE;
    assign hunt_inc = hunt_cnt + HUNT_ONE;
    assign tag_ch   = rx_byte[CH_W-1:0];
    assign tag_bad  = (rx_byte >= NUM_CH_B);
    assign in_block = (state == TAG) || (state == PAYLOAD) || (state == CRC);
    assign busy     = in_block;

    // Channel select decoded by comparison so non-power-of-two NUM_CH never indexes past ch_ready.
    always_comb begin
        sel_ready  = 1'b0;
        sel_onehot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cur_ch == CH_W'(i)) begin
                sel_ready     = ch_ready[i];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        byte_cnt_nxt   = byte_cnt;
        hunt_cnt_nxt   = hunt_cnt;
        cur_ch_nxt     = cur_ch;
        discard_nxt    = discard;
        wr_en_nxt      = '0;
        wr_data_nxt    = wr_data;
        block_done_nxt = 1'b0;
        block_ch_nxt   = block_ch;
        timeout_nxt    = 1'b0;
        abort_nxt      = 1'b0;
        err_tag_nxt    = clr_err ? 1'b0 : err_tag;
        err_ovf_nxt    = clr_err ? 1'b0 : err_ovf;
        end_payload    = 1'b0;
        end_block      = 1'b0;
        end_discard    = discard;
        end_ch         = cur_ch;

        if (!enable) begin
            state_nxt    = IDLE;
            byte_cnt_nxt = '0;
            hunt_cnt_nxt = '0;
            abort_nxt    = in_block;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nxt    = HUNT;
                    hunt_cnt_nxt = '0;
                    byte_cnt_nxt = '0;
                end
                HUNT: begin
                    if (rx_valid) begin
                        if (rx_byte == START_TOKEN) begin
                            state_nxt    = TAG;
                            hunt_cnt_nxt = '0;
                            byte_cnt_nxt = '0;
                        end else if (hunt_inc == HUNT_END) begin
                            timeout_nxt  = 1'b1;
                            hunt_cnt_nxt = '0;
                        end else begin
                            hunt_cnt_nxt = hunt_inc;
                        end
                    end
                end
                TAG: begin
                    if (rx_valid) begin
                        state_nxt    = PAYLOAD;
                        cur_ch_nxt   = tag_ch;
                        discard_nxt  = tag_bad;
                        byte_cnt_nxt = CNT_ONE;
                        if (tag_bad) begin
                            err_tag_nxt = 1'b1;
                        end
                        end_discard = tag_bad;
                        end_ch      = tag_ch;
                        end_payload = (CNT_ONE == PAY_END);
                    end
                end
                PAYLOAD: begin
                    if (rx_valid) begin
                        byte_cnt_nxt = byte_inc;
                        if (!discard) begin
                            if (sel_ready) begin
                                wr_en_nxt   = sel_onehot;
                                wr_data_nxt = rx_byte;
                            end else begin
                                err_ovf_nxt = 1'b1;
                            end
                        end
                        end_payload = (byte_inc == PAY_END);
                    end
                end
                CRC: begin
                    if (rx_valid) begin
                        byte_cnt_nxt = byte_inc;
                        end_block    = (byte_inc == CRC_END);
                    end
                end
                default: state_nxt = IDLE;
            endcase

            // With no CRC bytes the last payload byte closes the block directly.
            if (end_payload) begin
                if (CRC_BYTES == 0) begin
                    end_block = 1'b1;
                end else begin
                    state_nxt = CRC;
                end
            end

            if (end_block) begin
                state_nxt    = HUNT;
                byte_cnt_nxt = '0;
                hunt_cnt_nxt = '0;
                if (!end_discard) begin
                    block_done_nxt = 1'b1;
                    block_ch_nxt   = 3'(end_ch);
                end
            end
        end
    end

    always_ff @(posedge CLK_40 or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            hunt_cnt   <= '0;
            cur_ch     <= '0;
            discard    <= 1'b0;
            wr_en      <= '0;
            wr_data    <= '0;
            block_done <= 1'b0;
            block_ch   <= '0;
            timeout    <= 1'b0;
            abort      <= 1'b0;
            err_tag    <= 1'b0;
            err_ovf    <= 1'b0;
        end else begin
            state      <= state_nxt;
            byte_cnt   <= byte_cnt_nxt;
            hunt_cnt   <= hunt_cnt_nxt;
            cur_ch     <= cur_ch_nxt;
            discard    <= discard_nxt;
            wr_en      <= wr_en_nxt;
            wr_data    <= wr_data_nxt;
            block_done <= block_done_nxt;
            block_ch   <= block_ch_nxt;
            timeout    <= timeout_nxt;
            abort      <= abort_nxt;
            err_tag    <= err_tag_nxt;
            err_ovf    <= err_ovf_nxt;
        end
    end

endmodule

// File: doc/sd_block_demux.md
Name: sd_block_demux

Overview:
- Byte-level successor to the single-stream SD read path: consumes the SPI master's received-byte stream and hunts for a start token.
- Reads a one-byte channel tag, then routes the block payload to one of NUM_CH downstream buffers (video, audio, spare), discarding the trailing CRC.
- Sits between the SPI byte receiver and the per-channel FIFOs feeding the VGA and audio paths, all in the CLK_40 domain.

Parameters:
- NUM_CH, 2: number of output channels (tag 0 = video, 1 = audio, ...); range 1..8.
- BLOCK_BYTES, 512: bytes per block after the start token, including the tag byte.
- CRC_BYTES, 2: trailing bytes after each block, dropped.
- START_TOKEN, 8'hFE: byte value that opens a block.
- TIMEOUT_BYTES, 4096: non-token bytes tolerated in HUNT before a timeout.

Ports:
- CLK_40  in  1  system clock, 40 MHz
- reset  in  1  asynchronous, active-low reset
- enable  in  1  level; high = run, low = return to IDLE
- clr_err  in  1  pulse; clears sticky error flags
- rx_valid  in  1  one-cycle strobe: rx_byte holds a new received byte (no backpressure)
- rx_byte  in  8  received byte
- ch_ready  in  NUM_CH  per-channel downstream can accept a byte
- wr_en  out  NUM_CH  one-hot write strobe to the selected channel
- wr_data  out  8  payload byte
- block_done  out  1  pulse: a block with a valid tag completed, CRC consumed
- block_ch  out  3  channel of the last completed block
- timeout  out  1  pulse: HUNT byte budget exhausted
- abort  out  1  pulse: enable dropped in TAG/PAYLOAD/CRC
- err_tag  out  1  sticky: tag >= NUM_CH seen
- err_ovf  out  1  sticky: payload byte dropped because ch_ready was low
- busy  out  1  high in TAG, PAYLOAD, CRC

Behaviour:
- Reset (reset=0, async): state=IDLE, all counters 0. wr_en, wr_data, block_done, block_ch, timeout, abort, err_tag, err_ovf and busy are all 0.
- States: IDLE, HUNT, TAG, PAYLOAD, CRC. Only cycles with rx_valid=1 advance byte counters.
- IDLE: enable=1 -> HUNT next cycle; hunt counter cleared.
- HUNT: on rx_valid with rx_byte==START_TOKEN -> TAG, hunt counter cleared. Any other byte increments the hunt counter.
  - When the counter reaches TIMEOUT_BYTES, pulse timeout for 1 cycle, clear the counter and stay in HUNT.
- TAG: next valid byte is the tag; latch it into cur_ch and go to PAYLOAD with byte count=1.
  - If tag >= NUM_CH, set err_tag and mark the block discard; payload is still counted but never written.
- PAYLOAD: each valid byte increments the count.
  - Write: if not discard and ch_ready[cur_ch]=1, then wr_en[cur_ch]=1 and wr_data=rx_byte, registered, appearing the cycle after rx_valid.
  - Drop: if ch_ready[cur_ch]=0, the byte is dropped and err_ovf is set; no stall.
  - When count reaches BLOCK_BYTES: go to CRC, or straight to the done step if CRC_BYTES=0.
- CRC: count CRC_BYTES valid bytes, all ignored. After the last one:
  - if not discard: pulse block_done and load block_ch=cur_ch, both the cycle after the final rx_valid;
  - return to HUNT.
- wr_en is at most one-hot and is 0 on any cycle not following a written payload byte. wr_data holds its last value when wr_en=0.
- Latency: rx_valid to wr_en/wr_data is exactly 1 cycle. The final CRC byte to block_done is exactly 1 cycle.
- enable=0 in any state: next state IDLE and counters cleared.
  - If the state was TAG/PAYLOAD/CRC, pulse abort for 1 cycle.
  - A byte arriving in that same cycle is not written.
- clr_err=1 clears err_tag/err_ovf. If clr_err and a new error event coincide, the flag ends up set (set wins).
- A START_TOKEN value inside PAYLOAD or CRC is plain data.
- Back-to-back blocks: a token may arrive on the very next valid byte after the last CRC byte.
- Widths:
  - byte counter is $clog2(BLOCK_BYTES+CRC_BYTES+1) bits;
  - hunt counter is $clog2(TIMEOUT_BYTES+1) bits;
  - block_ch is zero-extended from cur_ch.

Test Plan:
- Bench uses NUM_CH=2, BLOCK_BYTES=8, CRC_BYTES=2, TIMEOUT_BYTES=16, ch_ready=2'b11.
1. Basic routing: send FF,FF,FE,01,A0..A6,C1,C2 -> wr_en=2'b10 seven times with data A0..A6, each 1 cycle after its rx_valid; block_done=1 with block_ch=1 one cycle after C2; err flags 0.
2. Bad tag: send FE,05, 7 data bytes, 2 CRC -> wr_en never asserts; err_tag=1; no block_done; the next FE,00 block routes to channel 0. Then pulse clr_err -> err_tag=0.
3. Backpressure: tag 0 block with ch_ready[0]=0 for payload bytes 3-4 -> only 5 writes occur, bytes 3-4 missing; err_ovf=1 sticky; block_done still pulses.
4. Timeout: 16 bytes of 8'hFF in HUNT -> timeout pulses once after the 16th; 32 bytes -> two pulses; a following FE is still accepted.
5. Abort: drop enable after the 3rd payload byte -> abort pulses 1 cycle, busy=0, no further wr_en; re-enable and send a full block -> normal delivery.
6. Async reset: assert reset=0 mid-PAYLOAD, off clock edge -> all outputs 0 immediately; after release, FE inside a fresh stream starts a new block correctly.
